inst_rom_resp: RTL and testbench
================================

Name: inst_rom_resp

Overview:
- Instruction-memory responder on the fetch side of the core. Answers the fetch stage's word-address requests with 32-bit instructions after one clock cycle.
- Also contains a byte-serial loader. The loader assembles little-endian bytes into words and writes them into the array while the core is held off.
- Sits between the fetch stage's ROM address/data pair and the external program-load source (UART/debug byte stream).

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array.
- ADDR_W, 12, word-index width; must equal log2(DEPTH_WORDS).
- LEN_W, 13, loader word-count width; must equal ADDR_W+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_addr_in  in  32  fetch byte address (`InstAddressBus`).
- rom_data_out  out  32  registered instruction word (`InstByteBus`).
- rom_valid_out  out  1  rom_data_out holds a real array word for the address presented the previous cycle.
- rom_err_out  out  1  registered; previous-cycle address was misaligned or out of range.
- ld_start_in  in  1  single-cycle pulse that starts a load.
- ld_len_in  in  LEN_W  number of words to load, sampled on ld_start_in.
- ld_byte_in  in  8  load data byte.
- ld_byte_valid_in  in  1  byte present this cycle.
- ld_ready_out  out  1  loader accepts a byte this cycle; a byte transfers when ld_byte_valid_in and ld_ready_out are both high.
- ld_busy_out  out  1  high while a load is in progress.
- ld_done_out  out  1  one-cycle pulse when a load completes.
- ld_err_out  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - rom_data_out = 32'h00000013 (NOP); rom_valid_out = 0; rom_err_out = 0.
  - ld_ready_out = 0, ld_busy_out = 0, ld_done_out = 0, ld_err_out = 0.
  - State = IDLE; byte counter, word counter and shift register cleared.
  - The memory array is not reset.
- Fetch read, latency 1 cycle, registered output:
  - Word index = rom_addr_in[ADDR_W+1:2].
  - If rom_addr_in[1:0] != 0, or rom_addr_in[31:ADDR_W+2] != 0: data = NOP, valid = 0, err = 1.
  - Else if state != IDLE: data = NOP, valid = 0, err = 0.
  - Else: data = mem[index], valid = 1, err = 0.
- Loader FSM, states IDLE, LOAD, DONE:
  - IDLE:
    - ld_start_in with ld_len_in == 0 → go to DONE; nothing is written.
    - ld_start_in with ld_len_in > DEPTH_WORDS → ld_err_out pulses next cycle; stay in IDLE.
    - ld_start_in with a valid nonzero ld_len_in → go to LOAD; word counter = 0, byte counter = 0, len latched.
  - LOAD:
    - ld_ready_out = 1.
    - Each accepted byte shifts into a 24-bit register; byte counter increments modulo 4.
    - On the 4th byte, write mem[word counter] = {byte3, byte2, byte1, byte0} (byte 0 is the first byte received) and increment the word counter.
    - When the written word is number len-1 → go to DONE.
  - DONE: ld_done_out = 1 for exactly one cycle, then go to IDLE.
  - ld_busy_out = 1 in LOAD and DONE.
  - ld_start_in outside IDLE is ignored, with no error.
- Write/read collision: a fetch in the same cycle as a load write always returns NOP with valid = 0, because state != IDLE.
- Reset mid-load: FSM returns to IDLE; words already written stay in the array; the partial word is discarded.
- Gaps in ld_byte_valid_in are allowed; state holds.
- Width rules: word counter is LEN_W bits; no wrap, since len ≤ DEPTH_WORDS is checked at start.

Decomposition:
- Shared defines file: `InstAddressBus`, `InstByteBus`, INST_NOP = 32'h00000013, loader state encodings.
- One natural sub-module: inst_rom_mem, a DEPTH_WORDS×32 array with a synchronous write port and a registered read port.
- The FSM, byte assembly and output muxing stay in the top level.

Test Plan:
- Reset low, then release, with rom_addr_in = 0 → rom_data_out = 32'h00000013, rom_valid_out = 0 until the first post-reset edge with IDLE; no ld pulses.
- Load len = 2 with bytes 13,05,10,00,93,05,20,00 → ld_done_out pulses once; fetch 0x0 gives 32'h00100513 and fetch 0x4 gives 32'h00200593, each valid one cycle after the address is applied.
- Fetch 0x2 → rom_err_out = 1, rom_valid_out = 0, rom_data_out = NOP. Fetch 0x00004000 with DEPTH 4096 → same response.
- Start with len = 4097 → ld_err_out pulses for one cycle, ld_busy_out stays 0. Start with len = 0 → ld_done_out pulses within 2 cycles and memory is unchanged.
- During a load, fetch 0x0 → rom_valid_out = 0 and rom_data_out = NOP throughout. A second ld_start_in mid-load → ignored, with the original length honoured.
- Assert rst after 5 bytes of a len = 2 load → ld_busy_out = 0 immediately, word 0 retained, word 1 unchanged; a new load then succeeds.

Source files
------------

// File: rtl/inst_rom_resp_pkg.sv
// Shared types and constants for the instruction ROM responder and its loader.
package inst_rom_resp_pkg;

    localparam int DEPTH_WORDS_DEF = 4096;
    localparam int ADDR_W_DEF      = 12;
    localparam int LEN_W_DEF       = 13;

    typedef logic [31:0] inst_address_bus_t;
    typedef logic [31:0] inst_byte_bus_t;

    localparam inst_byte_bus_t INST_NOP = 32'h00000013;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/inst_rom_mem.sv
// DEPTH_WORDS x 32 instruction array: synchronous write port, registered read port (1 cycle).
// No backpressure; the array itself is never reset.
module inst_rom_mem #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_rom_resp.sv
// Fetch-side instruction ROM (1-cycle registered response) with a byte-serial little-endian loader.
// Loader backpressure: ld_ready_out high only in LOAD; fetches answer NOP/invalid while a load runs.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LEN_W       = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  inst_address_bus_t    rom_addr_in,
    output inst_byte_bus_t       rom_data_out,
    output logic                 rom_valid_out,
    output logic                 rom_err_out,
    input  logic                 ld_start_in,
    input  logic [LEN_W-1:0]     ld_len_in,
    input  logic [7:0]           ld_byte_in,
    input  logic                 ld_byte_valid_in,
    output logic                 ld_ready_out,
    output logic                 ld_busy_out,
    output logic                 ld_done_out,
    output logic                 ld_err_out
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt;
    logic [1:0]       byte_cnt;
    logic [23:0]      shreg;
    logic             ld_err_q;
    logic             rom_valid_q;
    logic             rom_err_q;

    logic             bad_addr;
    logic             byte_acc;
    logic             mem_we;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    assign bad_addr  = (rom_addr_in[1:0] != 2'b00) || (rom_addr_in[31:ADDR_W+2] != '0);
    assign byte_acc  = (state == ST_LOAD) && ld_byte_valid_in;
    assign mem_we    = byte_acc && (byte_cnt == 2'd3);
    // The fourth byte goes straight to the array; earlier bytes sit in shreg, oldest lowest.
    assign mem_wdata = {ld_byte_in, shreg};

    inst_rom_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_cnt[ADDR_W-1:0]),
        .wdata (mem_wdata),
        .raddr (rom_addr_in[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ld_start_in) begin
                        if (ld_len_in == '0) begin
                            state <= ST_DONE;
                        end else if (ld_len_in > DEPTH_L) begin
                            ld_err_q <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            len_q    <= ld_len_in;
                            word_cnt <= '0;
                            byte_cnt <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (byte_acc) begin
                        shreg    <= {ld_byte_in, shreg[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= word_cnt + LEN_W'(1);
                            if (word_cnt == len_q - LEN_W'(1)) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Flags are registered alongside the array's registered read so data and status line up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_valid_q <= 1'b0;
            rom_err_q   <= 1'b0;
        end else begin
            rom_err_q   <= bad_addr;
            rom_valid_q <= !bad_addr && (state == ST_IDLE);
        end
    end

    assign rom_data_out  = rom_valid_q ? mem_rdata : INST_NOP;
    assign rom_valid_out = rom_valid_q;
    assign rom_err_out   = rom_err_q;
    assign ld_ready_out  = (state == ST_LOAD);
    assign ld_busy_out   = (state != ST_IDLE);
    assign ld_done_out   = (state == ST_DONE);
    assign ld_err_out    = ld_err_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Randomised bench for inst_rom_resp: scoreboard queue for fetch responses, behavioural loader model.
module tb_inst_rom_resp;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr_in;
    logic [31:0] rom_data_out;
    logic        rom_valid_out;
    logic        rom_err_out;
    logic        ld_start_in;
    logic [12:0] ld_len_in;
    logic [7:0]  ld_byte_in;
    logic        ld_byte_valid_in;
    logic        ld_ready_out;
    logic        ld_busy_out;
    logic        ld_done_out;
    logic        ld_err_out;

    inst_rom_resp dut (
        .clk              (clk),
        .rst              (rst),
        .rom_addr_in      (rom_addr_in),
        .rom_data_out     (rom_data_out),
        .rom_valid_out    (rom_valid_out),
        .rom_err_out      (rom_err_out),
        .ld_start_in      (ld_start_in),
        .ld_len_in        (ld_len_in),
        .ld_byte_in       (ld_byte_in),
        .ld_byte_valid_in (ld_byte_valid_in),
        .ld_ready_out     (ld_ready_out),
        .ld_busy_out      (ld_busy_out),
        .ld_done_out      (ld_done_out),
        .ld_err_out       (ld_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [int];
    logic [7:0]  bq[$];
    int          m_phase;
    int          m_len;
    int          m_widx;
    int          m_nb;
    logic [31:0] m_word;
    bit          last_acc;
    int          n_cmp;
    int          n_bad;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every response the DUT presents is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rom_valid", 32'(rom_valid_out), 32'(e.valid));
            check("rom_err", 32'(rom_err_out), 32'(e.err));
            if (e.chk_data) check("rom_data", rom_data_out, e.data);
        end
    end

    function automatic logic [31:0] pick_addr(bit fetch0);
        int r;
        if (fetch0) return 32'h0;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return ($urandom() & 32'hFFFF_FFFC) | 32'h0000_4000;
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    // One clock: predict the fetch response and the loader's next behaviour, then check ld_* flags.
    task automatic cycle();
        exp_t        e;
        logic [31:0] a;
        bit          err_exp;
        int          idx;
        a   = rom_addr_in;
        idx = int'(a[13:2]);
        e.err      = (a[1:0] != 2'b00) || (a[31:14] != 18'd0);
        e.valid    = !e.err && (m_phase == M_IDLE);
        e.chk_data = !e.valid || m_mem.exists(idx);
        e.data     = !e.valid ? NOP : (m_mem.exists(idx) ? m_mem[idx] : 32'h0);
        err_exp  = 1'b0;
        last_acc = 1'b0;
        case (m_phase)
            M_IDLE: if (ld_start_in) begin
                if (ld_len_in == 0) m_phase = M_DONE;
                else if (int'(ld_len_in) > 4096) err_exp = 1'b1;
                else begin
                    m_phase = M_LOAD; m_len = int'(ld_len_in);
                    m_widx = 0; m_nb = 0; m_word = 0;
                end
            end
            M_LOAD: if (ld_byte_valid_in) begin
                last_acc = 1'b1;
                m_word = m_word | (32'(ld_byte_in) << (8 * m_nb));
                m_nb++;
                if (m_nb == 4) begin
                    m_mem[m_widx] = m_word;
                    m_widx++; m_nb = 0; m_word = 0;
                    if (m_widx == m_len) m_phase = M_DONE;
                end
            end
            default: m_phase = M_IDLE;
        endcase
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        check("ld_busy", 32'(ld_busy_out), 32'(m_phase != M_IDLE));
        check("ld_done", 32'(ld_done_out), 32'(m_phase == M_DONE));
        check("ld_ready", 32'(ld_ready_out), 32'(m_phase == M_LOAD));
        check("ld_err", 32'(ld_err_out), 32'(err_exp));
        ld_start_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        ld_start_in = 1'b0; ld_byte_valid_in = 1'b0;
        #1;
        exp_q.delete();
        m_phase = M_IDLE; m_nb = 0; m_word = 0;
        check("rst_busy", 32'(ld_busy_out), 32'd0);
        check("rst_ready", 32'(ld_ready_out), 32'd0);
        check("rst_done", 32'(ld_done_out), 32'd0);
        check("rst_lderr", 32'(ld_err_out), 32'd0);
        check("rst_valid", 32'(rom_valid_out), 32'd0);
        check("rst_err", 32'(rom_err_out), 32'd0);
        check("rst_data", rom_data_out, NOP);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic idle(int n, bit fetch0);
        repeat (n) begin
            rom_addr_in = pick_addr(fetch0);
            cycle();
        end
    endtask

    task automatic fill_random(int words);
        bq.delete();
        repeat (4 * words) bq.push_back(8'($urandom()));
    endtask

    // Drives a load of bq's bytes; optionally resets after abort_after accepted bytes.
    task automatic load(int len, int gap_pct, int abort_after, bit fetch0);
        int guard;
        int sent;
        guard = 0; sent = 0;
        ld_start_in = 1'b1;
        ld_len_in   = 13'(len);
        rom_addr_in = pick_addr(fetch0);
        cycle();
        while (m_phase != M_IDLE && guard < 2000) begin
            guard++;
            if (abort_after >= 0 && sent == abort_after) begin
                do_reset();
                return;
            end
            ld_byte_valid_in = (bq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
            ld_byte_in       = (bq.size() > 0) ? bq[0] : 8'($urandom());
            if ($urandom_range(0, 19) == 0) begin
                ld_start_in = 1'b1;
                ld_len_in   = 13'($urandom_range(0, 8191));
            end
            rom_addr_in = pick_addr(fetch0);
            cycle();
            if (last_acc) begin
                void'(bq.pop_front());
                sent++;
            end
        end
        ld_byte_valid_in = 1'b0;
        if (guard >= 2000) check("load_timeout", 32'(guard), 32'd0);
        idle(1, fetch0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        m_phase = M_IDLE; m_len = 0; m_widx = 0; m_nb = 0; m_word = 0;
        rst = 1'b0; rom_addr_in = 32'h0;
        ld_start_in = 1'b0; ld_len_in = '0; ld_byte_in = '0; ld_byte_valid_in = 1'b0;
        do_reset();

        idle(2, 1'b1);
        bq = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        load(2, 0, -1, 1'b0);
        rom_addr_in = 32'h0;        cycle();
        rom_addr_in = 32'h4;        cycle();
        rom_addr_in = 32'h2;        cycle();
        rom_addr_in = 32'h0000_4000; cycle();

        bq.delete();
        load(4097, 0, -1, 1'b0);
        load(0, 0, -1, 1'b0);
        rom_addr_in = 32'h4;        cycle();

        fill_random(3);
        load(3, 40, -1, 1'b1);
        idle(2, 1'b0);

        fill_random(2);
        load(2, 0, 5, 1'b0);
        rom_addr_in = 32'h0;        cycle();
        rom_addr_in = 32'h4;        cycle();
        fill_random(2);
        load(2, 20, -1, 1'b0);
        rom_addr_in = 32'h4;        cycle();

        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 12);
            fill_random(len);
            load(len, 30, -1, 1'b0);
            idle(6, 1'b0);
        end
        bq.delete();
        load($urandom_range(4097, 8191), 0, -1, 1'b0);
        idle(8, 1'b0);

        @(negedge clk);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
